// File: rtl/lz77_pkg.sv
// Shared types and constants for the LZ77 encoder control path.
// Holds the sequencer state encoding, buffer depths and the emitted code record.
package lz77_pkg;

    localparam int          SB_DEPTH = 9;
    localparam int          LA_DEPTH = 8;
    localparam logic [7:0]  EOS_CHAR = 8'h24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SEARCH,
        S_EMIT,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [3:0] offset;
        logic [2:0] len;
        logic [7:0] chr;
    } code_t;

    // Longest codable match: one look-ahead entry is always kept back as char_nxt.
    function automatic logic [2:0] len_limit(input logic [3:0] cnt);
        if (cnt == 4'd0)
            return 3'd0;
        if (cnt >= 4'(LA_DEPTH))
            return 3'd7;
        return 3'(cnt - 4'd1);
    endfunction

endpackage

// File: rtl/lz77_best_match.sv
// Running best-match tracker: clamps each comparator length to the codable limit
// and keeps the first (smallest) offset on ties.
module lz77_best_match
    import lz77_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       update,
    input  logic [3:0] offset,
    input  logic [2:0] cmp_len,
    input  logic [2:0] lim,
    output logic [2:0] best_len,
    output logic [3:0] best_off,
    output logic [2:0] next_len
);

    logic [2:0] len;
    logic       take;

    always_comb begin
        len      = (cmp_len < lim) ? cmp_len : lim;
        take     = update && (len > best_len);
        next_len = take ? len : best_len;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_len <= 3'd0;
            best_off <= 4'd0;
        end else if (clear) begin
            best_len <= 3'd0;
            best_off <= 4'd0;
        end else if (take) begin
            best_len <= len;
            best_off <= offset;
        end
    end

endmodule

// File: rtl/lz77_match_scheduler.sv
// LZ77 encoder sequencer: waits for look-ahead fill, sweeps search offsets for the
// longest match, emits one (offset, len, char) code and requests the buffer slide.
module lz77_match_scheduler
    import lz77_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] la_cnt,
    input  logic [3:0] sb_cnt,
    input  logic       eos_loaded,
    output logic [3:0] cmp_offset,
    input  logic [2:0] cmp_len,
    output logic [2:0] char_sel,
    input  logic [7:0] char_in,
    output logic       shift_req,
    output logic [3:0] shift_amt,
    input  logic       shift_ack,
    output logic       valid,
    output logic       encode,
    output logic       finish,
    output logic [3:0] offset,
    output logic [2:0] match_len,
    output logic [7:0] char_nxt
);

    state_t     state, next_state;
    code_t      code_q;
    logic       eos_flag;
    logic       fill_ready;
    logic       search_done;
    logic       best_clear;
    logic       best_update;
    logic [2:0] lim;
    logic [2:0] best_len;
    logic [2:0] next_len;
    logic [3:0] best_off;

    lz77_best_match u_best (
        .clk      (clk),
        .reset    (reset),
        .clear    (best_clear),
        .update   (best_update),
        .offset   (cmp_offset),
        .cmp_len  (cmp_len),
        .lim      (lim),
        .best_len (best_len),
        .best_off (best_off),
        .next_len (next_len)
    );

    assign fill_ready  = (la_cnt == 4'(LA_DEPTH)) || (eos_loaded && (la_cnt != 4'd0));
    assign lim         = len_limit(la_cnt);
    assign search_done = (cmp_offset == sb_cnt - 4'd1) || (cmp_offset == 4'(SB_DEPTH - 1))
                         || (next_len == lim);

    assign encode    = 1'b1;
    assign char_sel  = best_len;
    assign offset    = code_q.offset;
    assign match_len = code_q.len;
    assign char_nxt  = code_q.chr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state  = state;
        best_clear  = 1'b0;
        best_update = 1'b0;
        case (state)
            S_IDLE:   if (start) next_state = S_FILL;
            S_FILL: begin
                if (fill_ready) begin
                    best_clear = 1'b1;
                    next_state = (sb_cnt == 4'd0) ? S_EMIT : S_SEARCH;
                end
            end
            S_SEARCH: begin
                best_update = 1'b1;
                if (search_done) next_state = S_EMIT;
            end
            S_EMIT:   next_state = S_SHIFT;
            S_SHIFT:  if (shift_req && shift_ack) next_state = eos_flag ? S_DONE : S_FILL;
            S_DONE:   if (start) next_state = S_FILL;
            default:  next_state = S_IDLE;
        endcase
    end

    // Slide request is raised one cycle after the code pulse and dropped on ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q     <= '0;
            valid      <= 1'b0;
            finish     <= 1'b0;
            eos_flag   <= 1'b0;
            shift_req  <= 1'b0;
            shift_amt  <= 4'd0;
            cmp_offset <= 4'd0;
        end else begin
            valid <= (state == S_EMIT);
            case (state)
                S_FILL:   if (fill_ready) cmp_offset <= 4'd0;
                S_SEARCH: if (!search_done) cmp_offset <= cmp_offset + 4'd1;
                S_EMIT: begin
                    code_q   <= '{offset: best_off, len: best_len, chr: char_in};
                    eos_flag <= (char_in == EOS_CHAR);
                end
                S_SHIFT: begin
                    if (!shift_req) begin
                        shift_req <= 1'b1;
                        shift_amt <= {1'b0, best_len} + 4'd1;
                    end else if (shift_ack) begin
                        shift_req <= 1'b0;
                        if (eos_flag) finish <= 1'b1;
                    end
                end
                S_DONE:   if (start) finish <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_match_scheduler.sv
// Bench for lz77_match_scheduler: models the buffer datapath with lookup tables and
// predicts each code, its latency and the slide handshake from the matching rules.
module tb_lz77_match_scheduler;
    import lz77_pkg::*;

    logic       clk = 1'b0;
    logic       reset, start, eos_loaded, shift_ack;
    logic [3:0] la_cnt, sb_cnt, cmp_offset, shift_amt, offset;
    logic [2:0] cmp_len, char_sel, match_len;
    logic [7:0] char_in, char_nxt;
    logic       shift_req, valid, encode, finish;

    logic [2:0] cmp_tbl [16];
    logic [7:0] la_tbl  [8];

    int vectors     = 0;
    int miscompares = 0;

    lz77_match_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .la_cnt     (la_cnt),
        .sb_cnt     (sb_cnt),
        .eos_loaded (eos_loaded),
        .cmp_offset (cmp_offset),
        .cmp_len    (cmp_len),
        .char_sel   (char_sel),
        .char_in    (char_in),
        .shift_req  (shift_req),
        .shift_amt  (shift_amt),
        .shift_ack  (shift_ack),
        .valid      (valid),
        .encode     (encode),
        .finish     (finish),
        .offset     (offset),
        .match_len  (match_len),
        .char_nxt   (char_nxt)
    );

    always #5 clk = ~clk;

    always_comb begin
        cmp_len = cmp_tbl[cmp_offset];
        char_in = la_tbl[char_sel];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected code straight from the matching rules: scan offsets in order,
    // keep strictly longer clamped runs, stop once the codable limit is reached.
    function automatic void model(input int sb, input int la, output int n,
                                  output int off, output int len);
        int lim = (la - 1 < 7) ? la - 1 : 7;
        n = 0; off = 0; len = 0;
        for (int o = 0; o < sb; o++) begin
            int l = (int'(cmp_tbl[o]) < lim) ? int'(cmp_tbl[o]) : lim;
            n++;
            if (l > len) begin
                len = l;
                off = o;
            end
            if (len == lim) break;
        end
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, " valid"},      valid,      0);
        check({tag, " encode"},     encode,     1);
        check({tag, " finish"},     finish,     0);
        check({tag, " offset"},     offset,     0);
        check({tag, " match_len"},  match_len,  0);
        check({tag, " char_nxt"},   char_nxt,   0);
        check({tag, " shift_req"},  shift_req,  0);
        check({tag, " shift_amt"},  shift_amt,  0);
        check({tag, " cmp_offset"}, cmp_offset, 0);
        check({tag, " char_sel"},   char_sel,   0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge with the DUT in FILL; returns at a negedge back in FILL.
    task automatic run_code(input int sb, input int la, input bit eos, input int stall,
                            input string tag);
        int n, eoff, elen, cyc;
        logic [7:0] echr;
        model(sb, la, n, eoff, elen);
        echr       = la_tbl[elen];
        sb_cnt     = 4'(sb);
        la_cnt     = 4'(la);
        eos_loaded = eos;
        shift_ack  = 1'b0;
        cyc        = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (!valid && cyc <= n) check({tag, " cmp_offset"}, cmp_offset, cyc - 1);
        end while (!valid && cyc < 20);
        check({tag, " latency"},   cyc,       n + 2);
        check({tag, " offset"},    offset,    eoff);
        check({tag, " match_len"}, match_len, elen);
        check({tag, " char_nxt"},  char_nxt,  echr);
        check({tag, " req_early"}, shift_req, 0);
        // An ack while no request is pending must be ignored.
        shift_ack = 1'b1;
        if (stall > 0) shift_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, " shift_req"}, shift_req, 1);
        check({tag, " shift_amt"}, shift_amt, elen + 1);
        check({tag, " valid_once"}, valid, 0);
        for (int i = 0; i < stall; i++) begin
            if (i == 1) start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            check({tag, " stall req"}, shift_req, 1);
            check({tag, " stall amt"}, shift_amt, elen + 1);
            check({tag, " stall valid"}, valid, 0);
        end
        shift_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        shift_ack  = 1'b0;
        la_cnt     = 4'd0;
        eos_loaded = 1'b0;
        check({tag, " req_drop"}, shift_req, 0);
        if (echr == EOS_CHAR) begin
            check({tag, " finish"}, finish, 1);
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                @(negedge clk);
                check({tag, " done valid"}, valid, 0);
                check({tag, " done finish"}, finish, 1);
            end
            pulse_start();
            check({tag, " finish_clr"}, finish, 0);
        end else begin
            check({tag, " finish"}, finish, 0);
        end
    endtask

    initial begin
        int cyc, sb, la;
        bit eos;
        reset = 1'b1; start = 1'b0; la_cnt = 4'd0; sb_cnt = 4'd0;
        eos_loaded = 1'b0; shift_ack = 1'b0;
        for (int i = 0; i < 16; i++) cmp_tbl[i] = 3'd0;
        for (int i = 0; i < 8; i++)  la_tbl[i]  = 8'h61 + 8'(i);
        #12;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b0;
        pulse_start();

        // First character: empty search buffer skips SEARCH entirely.
        la_tbl[0] = 8'h31;
        run_code(0, 8, 1'b0, 0, "first_char");

        // Equal runs at offsets 2 and 5: the smaller offset wins; slide stalled.
        for (int i = 0; i < 16; i++) cmp_tbl[i] = 3'd0;
        for (int i = 0; i < 8; i++)  la_tbl[i]  = 8'h40 + 8'(i);
        cmp_tbl[2] = 3'd3;
        cmp_tbl[5] = 3'd3;
        run_code(9, 8, 1'b0, 5, "tie_stall");

        // Asynchronous reset in the middle of a sweep.
        for (int i = 0; i < 16; i++) cmp_tbl[i] = 3'd0;
        sb_cnt = 4'd9; la_cnt = 4'd8;
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end while (cmp_offset != 4'd4 && cyc < 20);
        check("mid_search cmp_offset", cmp_offset, 4);
        reset = 1'b1;
        #1;
        check_reset_values("mid_search_reset");
        @(negedge clk);
        reset = 1'b0;
        la_cnt = 4'd0;
        pulse_start();

        // Full sweep with no match anywhere.
        for (int i = 0; i < 8; i++) la_tbl[i] = 8'h70 + 8'(i);
        run_code(9, 8, 1'b0, 0, "full_search");

        for (int t = 0; t < 40; t++) begin
            sb  = int'($urandom_range(0, 9));
            la  = int'($urandom_range(1, 8));
            eos = (la < 8) ? 1'b1 : ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 16; i++) cmp_tbl[i] = (i < 9) ? 3'($urandom_range(0, 7)) : 3'd0;
            for (int i = 0; i < 8; i++)  la_tbl[i]  = 8'h41 + 8'($urandom_range(0, 25));
            if (eos) la_tbl[la - 1] = EOS_CHAR;
            run_code(sb, la, eos, int'($urandom_range(0, 2)), "random");
        end

        // Clamp to la_cnt-1 with terminator: early exit, then DONE.
        for (int i = 0; i < 16; i++) cmp_tbl[i] = 3'd0;
        cmp_tbl[0] = 3'd7;
        la_tbl[0] = 8'h61; la_tbl[1] = 8'h62; la_tbl[2] = EOS_CHAR;
        run_code(9, 3, 1'b1, 0, "clamp_eos");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
